// File: rtl/controle_vagas.sv
// Parking-lot occupancy controller: one entry and one exit barrier sharing a
// single occupancy counter, with capacity enforcement and one-cycle event pulses.
module controle_vagas #(
  parameter int CAPACITY    = 16,
  parameter int CNT_W       = 5,
  parameter int OPEN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_ent,
  input  logic             sensor_sai,
  output logic             gate_ent_open,
  output logic             gate_sai_open,
  output logic             increment,
  output logic             decrement,
  output logic             denied_ent,
  output logic             error,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam int HOLD_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, CLEAR} gate_state_t;

  // Index 0 is the entry gate, index 1 the exit gate.
  gate_state_t       state [2];
  logic [HOLD_W-1:0] hold  [2];
  logic [1:0]        gate;
  logic [1:0]        sensor;
  logic [1:0]        prev;
  logic [1:0]        evt;
  logic [1:0]        acc;
  logic              sai_ok;

  assign sensor = {sensor_sai, sensor_ent};

  // A rising sensor level only counts as a new vehicle while its gate is idle.
  assign evt[0] = sensor[0] & ~prev[0] & (state[0] == IDLE);
  assign evt[1] = sensor[1] & ~prev[1] & (state[1] == IDLE);

  // An exit frees a space in the same cycle, so it can admit an entry at full;
  // an entry at empty likewise provides the vehicle a simultaneous exit consumes.
  assign sai_ok = evt[1] & (occupancy != '0);
  assign acc[0] = evt[0] & ((occupancy < CAP) | sai_ok);
  assign acc[1] = evt[1] & ((occupancy != '0) | acc[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        hold[i]  <= '0;
        gate[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          IDLE: begin
            if (acc[i]) begin
              state[i] <= OPEN;
              hold[i]  <= HOLD_LOAD;
              gate[i]  <= 1'b1;
            end
          end
          OPEN: begin
            if (hold[i] == '0) begin
              state[i] <= CLEAR;
              gate[i]  <= 1'b0;
            end else begin
              hold[i] <= hold[i] - 1'b1;
            end
          end
          CLEAR: begin
            if (!sensor[i]) state[i] <= IDLE;
          end
          default: begin
            state[i] <= IDLE;
            gate[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: history resets high so a sensor already active at reset release is not an event.
      prev       <= 2'b11;
      occupancy  <= '0;
      increment  <= 1'b0;
      decrement  <= 1'b0;
      denied_ent <= 1'b0;
      error      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev       <= sensor;
      increment  <= acc[0];
      decrement  <= acc[1];
      denied_ent <= evt[0] & ~acc[0];
      error      <= evt[1] & ~acc[1];
      case (acc)
        2'b01:   occupancy <= occupancy + 1'b1;
        2'b10:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign gate_ent_open = gate[0];
  assign gate_sai_open = gate[1];
  assign full          = (occupancy == CAP);
  assign empty         = (occupancy == '0);

endmodule

// File: tb/tb_controle_vagas.sv
// Self-checking bench for controle_vagas: directed scenarios plus randomized
// sensor traffic, all compared cycle by cycle against a behavioural model.
module tb_controle_vagas;

  localparam int CAPACITY    = 16;
  localparam int CNT_W       = 5;
  localparam int OPEN_CYCLES = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sensor_ent = 1'b1;
  logic             sensor_sai = 1'b1;
  logic             gate_ent_open, gate_sai_open;
  logic             increment, decrement, denied_ent, error;
  logic [CNT_W-1:0] occupancy;
  logic             full, empty;

  controle_vagas #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_ent(sensor_ent), .sensor_sai(sensor_sai),
    .gate_ent_open(gate_ent_open), .gate_sai_open(gate_sai_open),
    .increment(increment), .decrement(decrement),
    .denied_ent(denied_ent), .error(error),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: vehicle count, and per gate the number of cycles it will
  // still be held open plus a flag for "waiting for the vehicle to clear".
  int m_occ;
  bit m_ent_prev, m_sai_prev;
  int m_ent_left, m_sai_left;
  bit m_ent_clr, m_sai_clr;
  bit m_inc, m_dec, m_den, m_err;

  // Tallies observed on the DUT, used by the directed scenarios.
  int n_inc, n_dec, n_den, n_err, n_gate_ent, n_gate_sai;

  task automatic model_reset();
    m_occ = 0;
    m_ent_prev = 1'b1; m_sai_prev = 1'b1;
    m_ent_left = 0;    m_sai_left = 0;
    m_ent_clr = 1'b0;  m_sai_clr = 1'b0;
    m_inc = 1'b0; m_dec = 1'b0; m_den = 1'b0; m_err = 1'b0;
  endtask

  task automatic clear_tallies();
    n_inc = 0; n_dec = 0; n_den = 0; n_err = 0; n_gate_ent = 0; n_gate_sai = 0;
  endtask

  task automatic advance_gate(input bit accepted, input bit sens, inout int left, inout bit clr);
    if (accepted) left = OPEN_CYCLES;
    else if (left > 0) begin
      left--;
      if (left == 0) clr = 1'b1;
    end else if (clr && !sens) clr = 1'b0;
  endtask

  // Drive one cycle of sensor levels, advance the model, compare after the edge.
  task automatic cycle(input bit se, input bit ss);
    bit ent_new, sai_new, sai_alone, ent_ok, sai_ok;
    ent_new   = se && !m_ent_prev && m_ent_left == 0 && !m_ent_clr;
    sai_new   = ss && !m_sai_prev && m_sai_left == 0 && !m_sai_clr;
    sai_alone = sai_new && m_occ > 0;
    ent_ok    = ent_new && (CAPACITY - m_occ > 0 || sai_alone);
    sai_ok    = sai_new && (m_occ > 0 || ent_ok);
    m_inc = ent_ok;
    m_dec = sai_ok;
    m_den = ent_new && !ent_ok;
    m_err = sai_new && !sai_ok;
    m_occ = m_occ + int'(ent_ok) - int'(sai_ok);
    advance_gate(ent_ok, se, m_ent_left, m_ent_clr);
    advance_gate(sai_ok, ss, m_sai_left, m_sai_clr);
    m_ent_prev = se;
    m_sai_prev = ss;

    sensor_ent = se;
    sensor_sai = ss;
    @(posedge clk);
    #1;
    check("gate_ent_open", 32'(gate_ent_open), 32'(m_ent_left > 0));
    check("gate_sai_open", 32'(gate_sai_open), 32'(m_sai_left > 0));
    check("increment",     32'(increment),     32'(m_inc));
    check("decrement",     32'(decrement),     32'(m_dec));
    check("denied_ent",    32'(denied_ent),    32'(m_den));
    check("error",         32'(error),         32'(m_err));
    check("occupancy",     32'(occupancy),     32'(m_occ));
    check("full",          32'(full),          32'(m_occ == CAPACITY));
    check("empty",         32'(empty),         32'(m_occ == 0));
    n_inc += int'(increment);
    n_dec += int'(decrement);
    n_den += int'(denied_ent);
    n_err += int'(error);
    n_gate_ent += int'(gate_ent_open);
    n_gate_sai += int'(gate_sai_open);
  endtask

  task automatic one_entry();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (OPEN_CYCLES + 2) cycle(1'b0, 1'b0);
  endtask

  task automatic one_exit();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (OPEN_CYCLES + 2) cycle(1'b0, 1'b0);
  endtask

  task automatic async_reset_pulse();
    #3 reset = 1'b0;
    #1;
    check("rst_gate_ent", 32'(gate_ent_open), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    model_reset();
    #2 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #22;
    // Reset state with both sensors high.
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_gate_ent", 32'(gate_ent_open), 32'd0);
    check("reset_gate_sai", 32'(gate_sai_open), 32'd0);
    reset = 1'b1;

    // Sensor held high across reset release: not a vehicle.
    clear_tallies();
    repeat (3) cycle(1'b1, 1'b0);
    check("held_no_inc", 32'(n_inc), 32'd0);
    check("held_no_gate", 32'(n_gate_ent), 32'd0);

    // Single entry: one increment pulse, gate open exactly OPEN_CYCLES cycles.
    clear_tallies();
    one_entry();
    check("single_inc_count", 32'(n_inc), 32'd1);
    check("single_gate_cycles", 32'(n_gate_ent), 32'(OPEN_CYCLES));
    check("single_occupancy", 32'(occupancy), 32'd1);

    // Fill to capacity, then one refused entry.
    repeat (CAPACITY - 1) one_entry();
    check("fill_occupancy", 32'(occupancy), 32'(CAPACITY));
    check("fill_full", 32'(full), 32'd1);
    clear_tallies();
    one_entry();
    check("deny_count", 32'(n_den), 32'd1);
    check("deny_no_inc", 32'(n_inc), 32'd0);
    check("deny_no_gate", 32'(n_gate_ent), 32'd0);
    check("deny_occupancy", 32'(occupancy), 32'(CAPACITY));

    // Simultaneous entry and exit at full.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("swap_inc", 32'(increment), 32'd1);
    check("swap_dec", 32'(decrement), 32'd1);
    check("swap_gates", 32'({gate_ent_open, gate_sai_open}), 32'd3);
    check("swap_occupancy", 32'(occupancy), 32'(CAPACITY));
    repeat (OPEN_CYCLES + 2) cycle(1'b0, 1'b0);

    // Drain, then an exit against an empty lot.
    repeat (CAPACITY) one_exit();
    check("drain_empty", 32'(empty), 32'd1);
    clear_tallies();
    one_exit();
    check("underflow_error", 32'(n_err), 32'd1);
    check("underflow_no_dec", 32'(n_dec), 32'd0);
    check("underflow_no_gate", 32'(n_gate_sai), 32'd0);
    check("underflow_occupancy", 32'(occupancy), 32'd0);

    // Simultaneous entry and exit at empty.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("empty_swap_inc", 32'(increment), 32'd1);
    check("empty_swap_dec", 32'(decrement), 32'd1);
    check("empty_swap_err", 32'(error), 32'd0);
    repeat (OPEN_CYCLES + 2) cycle(1'b0, 1'b0);

    // Reset in the middle of an entry's open window at occupancy 5.
    repeat (4) one_entry();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("pre_reset_occupancy", 32'(occupancy), 32'd5);
    check("pre_reset_gate", 32'(gate_ent_open), 32'd1);
    async_reset_pulse();
    one_entry();
    check("post_reset_occupancy", 32'(occupancy), 32'd1);

    // Randomized traffic: entry-heavy phase to reach full, then mixed.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 2500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    async_reset_pulse();
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
